// File: rtl/arb_pkg.sv
// Shared definitions for the four-channel request arbiter: sizes, FSM state
// encoding and the one-hot helper used to build the grant vector.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  // IDLE arbitrates; BUSY holds the current owner until release or hold limit.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Convert a requester index into its one-hot grant pattern.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_4to2.sv
// Combinational 4-to-2 priority encoder; bit 3 has the highest priority.
// valid is high whenever any input bit is set; y is 0 when valid is low.
module prio_enc_4to2 (
  input  logic [3:0] in,
  output logic [1:0] y,
  output logic       valid
);

  // Pick the highest set bit.
  always_comb begin
    valid = |in;
    if (in[3])      y = 2'd3;
    else if (in[2]) y = 2'd2;
    else if (in[1]) y = 2'd1;
    else            y = 2'd0;
  end

endmodule

// File: rtl/req_arbiter_4ch.sv
// Four-requester arbiter with registered one-hot grant, ownership hold,
// hold-time limit and anti-starvation masking around a priority encoder.
// Optional macro ARB_ROUND_ROBIN_EN: rotates the search order so the last
// owner becomes lowest priority; undefined gives fixed priority 3>2>1>0.
module req_arbiter_4ch
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  // A zero MAX_HOLD disables the hold limit entirely.
  localparam bit             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               mask_valid_q, mask_valid_d;
  logic [ID_W-1:0]    mask_id_q, mask_id_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [ID_W-1:0]    gnt_id_d;
  logic               gnt_valid_d;
  logic               timeout_d;

  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] enc_in;
  logic [ID_W-1:0]    enc_y;
  logic               enc_valid;
  logic [ID_W-1:0]    winner;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0]    last_id_q, last_id_d;
`endif

  // Drop the requester that just timed out, unless it is the only one asking.
  always_comb begin
    req_masked = req & ~(mask_valid_q ? onehot4(mask_id_q) : '0);
    req_eff    = (|req_masked) ? req_masked : req;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Rotate so encoder bit 3 maps to (last_id-1) mod 4 and bit 0 to last_id.
  always_comb begin
    enc_in = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [ID_W-1:0] idx;
      idx       = ID_W'(k) + last_id_q;
      enc_in[k] = req_eff[idx];
    end
  end
`else
  // Fixed priority: feed the effective request straight to the encoder.
  always_comb begin
    enc_in = req_eff;
  end
`endif

  prio_enc_4to2 u_enc (
    .in    (enc_in),
    .y     (enc_y),
    .valid (enc_valid)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Undo the rotation; the 2-bit add wraps modulo 4.
  always_comb begin
    winner = enc_y + last_id_q;
  end
`else
  // Encoder index is the requester index directly.
  always_comb begin
    winner = enc_y;
  end
`endif

  // Next-state and next-output decode for the IDLE/BUSY ownership FSM.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d      = state_q;
    gnt_d        = gnt;
    gnt_id_d     = gnt_id;
    gnt_valid_d  = gnt_valid;
    timeout_d    = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    mask_valid_d = mask_valid_q;
    mask_id_d    = mask_id_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_id_d    = last_id_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d      = ST_BUSY;
          gnt_d        = onehot4(winner);
          gnt_id_d     = winner;
          gnt_valid_d  = 1'b1;
          hold_cnt_d   = '0;
          mask_valid_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_id_d    = winner;
`endif
        end
      end

      ST_BUSY: begin
        if (!req[gnt_id]) begin
          // Owner released: back to IDLE with no mask.
          state_d      = ST_IDLE;
          gnt_d        = '0;
          gnt_id_d     = '0;
          gnt_valid_d  = 1'b0;
          hold_cnt_d   = '0;
          mask_valid_d = 1'b0;
        end else if (HOLD_EN && (hold_cnt_q == HOLD_LAST)) begin
          // Hold limit reached: revoke and mask the owner for one arbitration.
          state_d      = ST_IDLE;
          gnt_d        = '0;
          gnt_id_d     = '0;
          gnt_valid_d  = 1'b0;
          timeout_d    = 1'b1;
          hold_cnt_d   = '0;
          mask_valid_d = 1'b1;
          mask_id_d    = gnt_id;
        end else begin
          hold_cnt_d   = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt          <= '0;
      gnt_id       <= '0;
      gnt_valid    <= 1'b0;
      timeout      <= 1'b0;
      hold_cnt_q   <= '0;
      mask_valid_q <= 1'b0;
      mask_id_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_id_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt          <= gnt_d;
      gnt_id       <= gnt_id_d;
      gnt_valid    <= gnt_valid_d;
      timeout      <= timeout_d;
      hold_cnt_q   <= hold_cnt_d;
      mask_valid_q <= mask_valid_d;
      mask_id_q    <= mask_id_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_id_q    <= last_id_d;
`endif
    end
  end

  // Grant must be one-hot or zero, and gnt_valid must track it.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_valid   : assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));

endmodule

// File: tb/tb_req_arbiter_4ch.sv
// Directed bench for req_arbiter_4ch: reset, hold/release, fixed order,
// hold-limit timeout with masking, round-robin order, and MAX_HOLD=0.
module tb_req_arbiter_4ch;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  logic [3:0] req0;
  logic [3:0] gnt0;
  logic [1:0] gnt_id0;
  logic       gnt_valid0;
  logic       timeout0;

  int total;
  int bad;

  req_arbiter_4ch #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  req_arbiter_4ch #(.MAX_HOLD(0), .CNT_W(5)) dut_nolimit (
    .clk       (clk),
    .rst       (rst),
    .req       (req0),
    .gnt       (gnt0),
    .gnt_id    (gnt_id0),
    .gnt_valid (gnt_valid0),
    .timeout   (timeout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    req0 = 4'b0000;
    tick();
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_gnt_valid: got %b want 0", gnt_valid); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst = 1'b0;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL idle_no_req: got %b want 0000", gnt); end
  endtask

  task automatic test_basic_hold();
    req = 4'b0110;                       // cycle 0
    tick();                              // cycle 1
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL basic_gnt: got %b want 0100", gnt); end
    total++; if (gnt_id !== 2'd2) begin bad++; $display("FAIL basic_gnt_id: got %0d want 2", gnt_id); end
    total++; if (gnt_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", gnt_valid); end
    repeat (4) tick();                   // cycle 5
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL basic_held: got %b want 0100", gnt); end
    req = 4'b0010;
    tick();                              // cycle 6
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL basic_release: got %b want 0000", gnt); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL basic_release_valid: got %b want 0", gnt_valid); end
    tick();                              // cycle 7
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL basic_next_gnt: got %b want 0010", gnt); end
    total++; if (gnt_id !== 2'd1) begin bad++; $display("FAIL basic_next_id: got %0d want 1", gnt_id); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b1111;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL midrst_pre_gnt: got %b want 1000", gnt); end
    tick();
    rst = 1'b1;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL midrst_gnt: got %b want 0000", gnt); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", gnt_valid); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL midrst_timeout: got %b want 0", timeout); end
    rst = 1'b0;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL midrst_regrant: got %b want 1000", gnt); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_fixed_order();
    logic [1:0] exp_id [4];
    logic [3:0] exp_oh;
    exp_id = '{2'd3, 2'd2, 2'd1, 2'd0};
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      tick();
      exp_oh = 4'b0001 << exp_id[n];
      total++; if (gnt_id !== exp_id[n]) begin bad++; $display("FAIL order_id[%0d]: got %0d want %0d", n, gnt_id, exp_id[n]); end
      total++; if (gnt !== exp_oh) begin bad++; $display("FAIL order_gnt[%0d]: got %b want %b", n, gnt, exp_oh); end
      tick();
      tick();
      req = req & ~exp_oh;
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL order_gap[%0d]: got %b want 0000", n, gnt); end
    end
    tick();
  endtask

  task automatic test_timeout();
    int held;
    req = 4'b1100;
    tick();
    held = 0;
    for (int i = 0; i < 40; i++) begin
      if (gnt !== 4'b1000) break;
      held++;
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early_pulse: got %b want 0 at %0d", timeout, i); end
      tick();
    end
    total++; if (held !== 16) begin bad++; $display("FAIL to_hold_len: got %0d want 16", held); end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_pulse: got %b want 1", timeout); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL to_gap: got %b want 0000", gnt); end
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL to_masked_next: got %b want 0100", gnt); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_width: got %b want 0", timeout); end
    // Owner 2 drops; only 3 asks from now on.
    req = 4'b1000;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL to_drop2: got %b want 0000", gnt); end
    tick();
    held = 0;
    for (int i = 0; i < 40; i++) begin
      if (gnt !== 4'b1000) break;
      held++;
      tick();
    end
    total++; if (held !== 16) begin bad++; $display("FAIL to_sole_hold_len: got %0d want 16", held); end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sole_pulse: got %b want 1", timeout); end
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL to_sole_regrant: got %b want 1000", gnt); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [6];
    logic [3:0] oh;
`ifdef ARB_ROUND_ROBIN_EN
    exp_id = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
`else
    exp_id = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      tick();
      total++; if (gnt_id !== exp_id[n]) begin bad++; $display("FAIL rr_id[%0d]: got %0d want %0d", n, gnt_id, exp_id[n]); end
      total++; if (!$onehot(gnt)) begin bad++; $display("FAIL rr_onehot[%0d]: got %b want one-hot", n, gnt); end
      oh  = 4'b0001 << gnt_id;
      req = 4'b1111 & ~oh;
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_gap[%0d]: got %b want 0000", n, gnt); end
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_max_hold_zero();
    int wrong_gnt;
    int pulses;
    req0 = 4'b0001;
    tick();
    total++; if (gnt0 !== 4'b0001) begin bad++; $display("FAIL nolimit_first: got %b want 0001", gnt0); end
    wrong_gnt = 0;
    pulses    = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (gnt0 !== 4'b0001) wrong_gnt++;
      if (timeout0 !== 1'b0) pulses++;
    end
    total++; if (wrong_gnt !== 0) begin bad++; $display("FAIL nolimit_hold: got %0d bad cycles want 0", wrong_gnt); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL nolimit_timeout: got %0d pulses want 0", pulses); end
    req0 = 4'b0000;
    tick();
    total++; if (gnt0 !== 4'b0000) begin bad++; $display("FAIL nolimit_release: got %b want 0000", gnt0); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    req0  = 4'b0000;
    test_reset();
    test_basic_hold();
    test_reset_mid_grant();
    test_fixed_order();
    test_timeout();
    test_round_robin();
    test_max_hold_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
